// File: rtl/fetch_if.sv
// fetch_if: branch, instruction-memory and decode-side signals of fetch.
// master = fetch unit, slave = memory / decode / branch environment.
interface fetch_if;
   logic        pc_src;
   logic [15:0] branch_target;
   logic        stall;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ready;
   logic [15:0] imem_rdata;
   logic        if_valid;
   logic [15:0] if_instr;
   logic [15:0] if_pc;

   modport master (
      input  pc_src, branch_target, stall,
      input  imem_ready, imem_rdata,
      output imem_req, imem_addr,
      output if_valid, if_instr, if_pc
   );

   modport slave (
      output pc_src, branch_target, stall,
      output imem_ready, imem_rdata,
      input  imem_req, imem_addr,
      input  if_valid, if_instr, if_pc
   );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, reads imem over req/ready and feeds decode
// through an output register backed by a one-entry skid buffer.
module fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] PC_STEP  = 16'd2
) (
   input logic     clk,
   input logic     rst,
   fetch_if.master bus
);

   typedef enum logic [1:0] {
      BOOT, FETCH, SKID, DRAIN
   } state_t;

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] pc;
   } entry_t;

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] hold_q, hold_d;
   logic        vld_q, vld_d;
   entry_t      out_q, out_d;
   entry_t      skid_q, skid_d;
   logic [15:0] tgt;
   logic        rdy;

   assign tgt = {bus.branch_target[15:1], 1'b0};
   assign rdy = bus.imem_ready;

   // state, pc, output register and skid entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         hold_q  <= '0;
         vld_q   <= 1'b0;
         out_q   <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         hold_q  <= hold_d;
         vld_q   <= vld_d;
         out_q   <= out_d;
         skid_q  <= skid_d;
      end
   end

   // next state and datapath; a redirect overrides capture and stall
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      hold_d  = hold_q;
      vld_d   = vld_q;
      out_d   = out_q;
      skid_d  = skid_q;
      unique case (state_q)
         BOOT: state_d = FETCH;
         FETCH: begin
            if (rdy) begin
               pc_d = pc_q + PC_STEP;
               if (!vld_q || !bus.stall) begin
                  out_d = '{instr: bus.imem_rdata, pc: pc_q};
                  vld_d = 1'b1;
               end else begin
                  skid_d  = '{instr: bus.imem_rdata, pc: pc_q};
                  state_d = SKID;
               end
            end else if (!bus.stall) begin
               vld_d = 1'b0;
            end
         end
         SKID: begin
            if (!bus.stall) begin
               out_d   = skid_q;
               vld_d   = 1'b1;
               state_d = FETCH;
            end
         end
         DRAIN: begin
            if (rdy) state_d = FETCH;
         end
         default: state_d = BOOT;
      endcase
      if (bus.pc_src) begin
         pc_d    = tgt;
         vld_d   = 1'b0;
         out_d   = out_q;
         skid_d  = skid_q;
         state_d = FETCH;
         if (state_q == FETCH) hold_d = pc_q;
         if ((state_q == FETCH || state_q == DRAIN) && !rdy)
            state_d = DRAIN;
      end
   end

   // DRAIN keeps presenting the abandoned address until it completes
   always_comb begin
      bus.imem_req  = 1'b0;
      bus.imem_addr = '0;
      unique case (state_q)
         FETCH: begin
            bus.imem_req  = 1'b1;
            bus.imem_addr = pc_q;
         end
         DRAIN: begin
            bus.imem_req  = 1'b1;
            bus.imem_addr = hold_q;
         end
         default: ;
      endcase
   end

   assign bus.if_valid = vld_q;
   assign bus.if_instr = out_q.instr;
   assign bus.if_pc    = out_q.pc;

endmodule
